xc_aessub: RTL and testbench

XC_AESSUB -- requirements
Module: xc_aessub

---
 rtl/xc_aes_pkg.sv | 50 +++++
 rtl/xc_aessub_if.sv | 22 ++
 rtl/xc_aessub_sbox.sv | 12 +
 rtl/xc_aessub.sv | 122 ++++++++++++
 tb/tb_xc_aessub.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xc_aes_pkg.sv
// Shared AES constants: forward/inverse S-box tables and the SubBytes sequencer states.
package xc_aes_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } seq_state_t;

    // Element 0 sits in the most significant byte of each concatenation.
    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/xc_aessub_if.sv
// Request/result bundle between the issuing pipeline and the SubBytes unit.
interface xc_aessub_if;
    logic        flush;
    logic [31:0] flush_data;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        rot;
    logic        ready;
    logic [31:0] result;

    modport master (
        output flush, flush_data, valid, rs1, rs2, enc, rot,
        input  ready, result
    );

    modport slave (
        input  flush, flush_data, valid, rs1, rs2, enc, rot,
        output ready, result
    );
endinterface

// File: rtl/xc_aessub_sbox.sv
// Single AES S-box lookup, forward or inverse, purely combinational.
module xc_aessub_sbox
    import xc_aes_pkg::*;
(
    input  logic [7:0] din,
    input  logic       enc,
    output logic [7:0] dout
);
    always_comb begin
        dout = enc ? SBOX_FWD[din] : SBOX_INV[din];
    end
endmodule

// File: rtl/xc_aessub.sv
// Packed SubBytes on ShiftRows-selected bytes; FAST picks four parallel S-boxes or one shared over 4 cycles.
module xc_aessub
    import xc_aes_pkg::*;
#(
    parameter logic FAST = 1'b0
)(
    input  logic         clock,
    input  logic         resetn,
    xc_aessub_if.slave   bus
);
    logic [3:0][7:0] t;
    logic [3:0][7:0] s;
    logic            ready;

    logic unused_in;
    assign unused_in = ^{bus.rs1[31:24], bus.rs1[15:8], bus.rs2[23:16],
                         bus.rs2[7:0], bus.flush_data[31:24]};

    always_comb begin
        t[0] = bus.rs1[7:0]   & {8{bus.valid}};
        t[1] = bus.rs2[15:8]  & {8{bus.valid}};
        t[2] = bus.rs1[23:16] & {8{bus.valid}};
        t[3] = bus.rs2[31:24] & {8{bus.valid}};
    end

    generate
        if (FAST) begin : g_fast
            logic unused_fast;
            assign unused_fast = ^{clock, bus.flush, bus.flush_data[23:0]};

            for (genvar i = 0; i < 4; i++) begin : g_sbox
                xc_aessub_sbox u_sbox (
                    .din  (t[i]),
                    .enc  (bus.enc),
                    .dout (s[i])
                );
            end

            always_comb begin
                ready = bus.valid & resetn;
            end
        end else begin : g_seq
            seq_state_t state, state_nxt;
            logic [7:0] b0, b1, b2;
            logic [7:0] sb_in, sb_out;

            xc_aessub_sbox u_sbox (
                .din  (sb_in),
                .enc  (bus.enc),
                .dout (sb_out)
            );

            always_ff @(posedge clock) begin
                if (!resetn) begin
                    state <= S0;
                end else if (bus.flush) begin
                    state <= S0;
                end else begin
                    state <= state_nxt;
                end
            end

            always_comb begin
                state_nxt = state;
                if (bus.valid) begin
                    case (state)
                        S0: state_nxt = S1;
                        S1: state_nxt = S2;
                        S2: state_nxt = S3;
                        S3: state_nxt = S0;
                        default: state_nxt = S0;
                    endcase
                end
            end

            always_ff @(posedge clock) begin
                if (!resetn) begin
                    b0 <= '0;
                    b1 <= '0;
                    b2 <= '0;
                end else if (bus.flush) begin
                    b0 <= bus.flush_data[7:0];
                    b1 <= bus.flush_data[15:8];
                    b2 <= bus.flush_data[23:16];
                end else if (bus.valid) begin
                    case (state)
                        S0: b0 <= sb_out;
                        S1: b1 <= sb_out;
                        S2: b2 <= sb_out;
                        default: ;
                    endcase
                end
            end

            // The last byte bypasses the registers so the result appears in the S3 cycle itself.
            always_comb begin
                sb_in = t[0];
                ready = 1'b0;
                case (state)
                    S0: sb_in = t[0];
                    S1: sb_in = t[1];
                    S2: sb_in = t[2];
                    S3: begin
                        sb_in = t[3];
                        ready = bus.valid & resetn;
                    end
                    default: sb_in = t[0];
                endcase
                s = {sb_out, b2, b1, b0};
            end
        end
    endgenerate

    always_comb begin
        bus.result = '0;
        if (ready) begin
            bus.result = bus.rot ? {s[0], s[3], s[2], s[1]} : s;
        end
        bus.ready = ready;
    end

endmodule

// File: tb/tb_xc_aessub.sv
// Bench for xc_aessub: sequenced and parallel instances against a GF(2^8) arithmetic S-box model.
module tb_xc_aessub;
    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    xc_aessub_if s_if ();
    xc_aessub_if f_if ();

    xc_aessub #(.FAST(1'b0)) u_slow (.clock(clock), .resetn(resetn), .bus(s_if));
    xc_aessub #(.FAST(1'b1)) u_fast (.clock(clock), .resetn(resetn), .bus(f_if));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        enc;
        logic        rot;
        logic        valid;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sub_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sub_inv(input logic [7:0] y);
        return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b,
                                             input logic e, input logic r);
        logic [7:0] tb [4];
        logic [7:0] sb [4];
        tb[0] = a[7:0];
        tb[1] = b[15:8];
        tb[2] = a[23:16];
        tb[3] = b[31:24];
        for (int i = 0; i < 4; i++) sb[i] = e ? sub_fwd(tb[i]) : sub_inv(tb[i]);
        return r ? {sb[0], sb[3], sb[2], sb[1]} : {sb[3], sb[2], sb[1], sb[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_slow(input logic [31:0] a, input logic [31:0] b, input logic e, input logic r);
        s_if.rs1 = a;
        s_if.rs2 = b;
        s_if.enc = e;
        s_if.rot = r;
    endtask

    // One request on the sequenced unit, optionally stalling before the given valid cycle.
    task automatic slow_req(input logic [31:0] a, input logic [31:0] b, input logic e, input logic r,
                            input int stall_at, input int stall_len, input logic [31:0] exp,
                            input string name);
        int vc;
        int st;
        int budget;
        vc = 0;
        st = 0;
        budget = 6 + stall_len;
        while (vc < 4 && budget > 0) begin
            budget--;
            @(posedge clock); #1;
            drive_slow(a, b, e, r);
            if (vc == stall_at && st < stall_len) begin
                s_if.valid = 1'b0;
                st++;
            end else begin
                s_if.valid = 1'b1;
            end
            @(negedge clock);
            if (s_if.valid) begin
                vc++;
                if (vc < 4) begin
                    chk({name, "_busy"}, {31'd0, s_if.ready}, 32'd0);
                end else begin
                    chk({name, "_ready"}, {31'd0, s_if.ready}, 32'd1);
                    chk({name, "_result"}, s_if.result, exp);
                end
            end else begin
                chk({name, "_stall"}, {s_if.ready, s_if.result[30:0]}, 32'd0);
            end
        end
        if (vc < 4) chk({name, "_timeout"}, 32'(vc), 32'd4);
    endtask

    task automatic slow_idle(input string name);
        @(posedge clock); #1;
        s_if.valid = 1'b0;
        s_if.flush = 1'b0;
        @(negedge clock);
        chk({name, "_idle_ready"}, {31'd0, s_if.ready}, 32'd0);
        chk({name, "_idle_result"}, s_if.result, 32'd0);
    endtask

    task automatic slow_partial(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            drive_slow(32'h00530001, 32'hff000000, 1'b1, 1'b0);
            s_if.valid = 1'b1;
            @(negedge clock);
            chk({name, "_partial"}, {31'd0, s_if.ready}, 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{32'h00530001, 32'hff000000, 1'b1, 1'b0, 1'b1, 32'h16ed637c};
        vecs[1] = '{32'h00530001, 32'hff000000, 1'b1, 1'b1, 1'b1, 32'h7c16ed63};
        vecs[2] = '{32'h00ed007c, 32'h16006300, 1'b0, 1'b0, 1'b1, 32'hff530001};
        vecs[3] = '{32'h00ed007c, 32'h16006300, 1'b0, 1'b1, 1'b1, 32'h01ff5300};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h63636363};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h52525252};
        vecs[6] = '{32'hffffffff, 32'hffffffff, 1'b1, 1'b0, 1'b1, 32'h16161616};
        vecs[7] = '{32'h00530001, 32'hff000000, 1'b1, 1'b0, 1'b0, 32'h00000000};

        resetn = 1'b0;
        s_if.flush = 1'b0; s_if.flush_data = '0; s_if.valid = 1'b1;
        drive_slow(32'h00530001, 32'hff000000, 1'b1, 1'b0);
        f_if.flush = 1'b0; f_if.flush_data = '0; f_if.valid = 1'b1;
        f_if.rs1 = 32'h00530001; f_if.rs2 = 32'hff000000; f_if.enc = 1'b1; f_if.rot = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_slow_ready", {31'd0, s_if.ready}, 32'd0);
        chk("rst_slow_result", s_if.result, 32'd0);
        chk("rst_fast_ready", {31'd0, f_if.ready}, 32'd0);
        chk("rst_fast_result", f_if.result, 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        s_if.valid = 1'b0;
        f_if.valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            f_if.rs1 = vecs[i].rs1; f_if.rs2 = vecs[i].rs2;
            f_if.enc = vecs[i].enc; f_if.rot = vecs[i].rot; f_if.valid = vecs[i].valid;
            @(negedge clock);
            chk($sformatf("fast_vec%0d_ready", i), {31'd0, f_if.ready}, {31'd0, vecs[i].valid});
            chk($sformatf("fast_vec%0d_result", i), f_if.result, vecs[i].exp);
        end

        for (int i = 0; i < 7; i++) begin
            slow_req(vecs[i].rs1, vecs[i].rs2, vecs[i].enc, vecs[i].rot, 0, 0,
                     vecs[i].exp, $sformatf("slow_vec%0d", i));
        end
        slow_idle("after_vecs");

        slow_req(32'h00530001, 32'hff000000, 1'b1, 1'b0, 2, 2, 32'h16ed637c, "stall");
        slow_idle("after_stall");

        slow_partial(2, "rst_mid");
        @(posedge clock); #1;
        resetn = 1'b0;
        f_if.valid = 1'b1;
        @(negedge clock);
        chk("rst_mid_slow", {s_if.ready, s_if.result[30:0]}, 32'd0);
        chk("rst_mid_fast", {f_if.ready, f_if.result[30:0]}, 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        s_if.valid = 1'b0;
        f_if.valid = 1'b0;
        @(negedge clock);
        chk("rst_after_ready", {31'd0, s_if.ready}, 32'd0);
        slow_req(32'h00ed007c, 32'h16006300, 1'b0, 1'b0, 0, 0, 32'hff530001, "rst_restart");
        slow_idle("after_rst");

        slow_partial(2, "flush_mid");
        @(posedge clock); #1;
        s_if.flush = 1'b1;
        s_if.flush_data = 32'hA5A5A5A5;
        @(negedge clock);
        chk("flush_cycle_ready", {31'd0, s_if.ready}, 32'd0);
        slow_idle("flush_after");
        slow_req(32'h00530001, 32'hff000000, 1'b1, 1'b0, 0, 0, 32'h16ed637c, "flush_restart");

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            logic e, r;
            a = $urandom; b = $urandom;
            e = 1'($urandom_range(1, 0)); r = 1'($urandom_range(1, 0));
            slow_req(a, b, e, r, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                     ref_word(a, b, e, r), $sformatf("rnd_slow%0d", n));
            if ($urandom_range(1, 0) == 0) slow_idle($sformatf("rnd_slow%0d", n));
        end
        slow_idle("after_rnd");

        for (int n = 0; n < 40; n++) begin
            logic [31:0] exp;
            @(posedge clock); #1;
            f_if.rs1 = $urandom; f_if.rs2 = $urandom;
            f_if.enc = 1'($urandom_range(1, 0)); f_if.rot = 1'($urandom_range(1, 0));
            f_if.valid = 1'($urandom_range(3, 0) != 0);
            exp = f_if.valid ? ref_word(f_if.rs1, f_if.rs2, f_if.enc, f_if.rot) : 32'h0;
            @(negedge clock);
            chk($sformatf("rnd_fast%0d_ready", n), {31'd0, f_if.ready}, {31'd0, f_if.valid});
            chk($sformatf("rnd_fast%0d_result", n), f_if.result, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
